// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default word/oversample sizes.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state (even parity).
package uart_pkg;

   localparam int UART_DEFAULT_N   = 8;
   localparam int UART_DEFAULT_OSR = 16;

   // Receiver states; PARITY only exists when parity checking is built in.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY    = 3'd3,
`endif
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so that
// reset never looks like a start bit arriving on an idle line.
module uart_sync2 (
   input  logic clk_i,
   input  logic nrst_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   // Shift the raw line through two flops; synchronous active-low reset to idle level.
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, N data bits MSB first, optional even
// parity bit, one stop bit. All bit samples are taken mid-bit, OSR/2 cycles after
// the detected falling edge and every OSR cycles after that.
// Optional feature macro: UART_RX_PARITY_EN (PARITY state + even parity check).
//
// Handshake: valid is a one-cycle pulse; data is only meaningful on that cycle and
// holds until the next pulse. There is no back-pressure: the consumer must accept
// every pulse. frame_err / parity_err are one-cycle pulses aligned with the event.
module uart_rx
   import uart_pkg::*;
#(
   parameter int N   = UART_DEFAULT_N,
   parameter int OSR = UART_DEFAULT_OSR
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         rxd,
   output logic [N-1:0] data,
   output logic         valid,
   output logic         frame_err,
   output logic         parity_err,
   output logic         busy,
   output rx_state_e    dbg_state_o
);

   localparam int CW = $clog2(OSR);
   localparam int BW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(OSR - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(OSR / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

   logic          rxs;
   logic          rxs_prev_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [N-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic          par_q, par_d;
   logic          perr_q, perr_d;
`endif

   uart_sync2 u_sync (
      .clk_i  (clk),
      .nrst_i (nrst),
      .d_i    (rxd),
      .q_o    (rxs)
   );

   // State, counters, shift register and output pulse registers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         rxs_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         // Tracked in every state so an edge right after the stop sample is seen in IDLE.
         rxs_prev_q <= rxs;
`ifdef UART_RX_PARITY_EN
         par_q      <= par_d;
         perr_q     <= perr_d;
`endif
      end
   end

   // Next-state logic: mid-bit sampling driven by the wrapping oversample counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (rxs_prev_q && !rxs) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               bit_d = '0;
`ifdef UART_RX_PARITY_EN
               par_d = 1'b0;
`endif
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_MAX) begin
               shift_d = (shift_q << 1) | N'(rxs);
               bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
               par_d   = par_q ^ rxs;
               if (bit_q == BIT_LAST) state_d = PARITY;
`else
               if (bit_q == BIT_LAST) state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_MAX) begin
               par_d   = par_q ^ rxs;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_MAX) begin
               if (rxs) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = par_q;
`endif
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign frame_err   = ferr_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = perr_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus random frames, checked against a
// frame-level reference model (word in -> expected word / parity flag / latency).
`timescale 1ns/1ps
module tb_uart_rx;
   import uart_pkg::*;

   localparam int N   = 8;
   localparam int OSR = 16;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         rxd = 1'b1;
   logic [N-1:0] data;
   logic         valid, frame_err, parity_err, busy;
   rx_state_e    dbg_state;

   int unsigned  cyc = 0;
   int unsigned  n_chk = 0;
   int unsigned  pass_cnt = 0;
   int unsigned  valid_n = 0, ferr_n = 0, perr_n = 0;

   logic [N-1:0] exp_q[$];
   logic         exp_perr_q[$];
   logic [N-1:0] got_q[$];
   logic         got_perr_q[$];
   int unsigned  got_cyc_q[$];

   uart_rx #(.N(N), .OSR(OSR)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .rxd         (rxd),
      .data        (data),
      .valid       (valid),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record output pulses on the falling edge
   always @(negedge clk) begin
      if (valid) begin
         valid_n++;
         got_q.push_back(data);
         got_perr_q.push_back(parity_err);
         got_cyc_q.push_back(cyc);
      end
      if (frame_err) ferr_n++;
      if (parity_err) perr_n++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame on the line. abort_bit >= 0 pulses nrst mid data bit abort_bit
   // and then returns the line to idle.
   task automatic send_frame(input logic [N-1:0] w, input logic bad_par,
                             input logic stop, input int abort_bit);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = N - 1; i >= 0; i--) bits.push_back(w[i]);
      if (P == 1) bits.push_back((^w) ^ bad_par);
      bits.push_back(stop);
      for (int b = 0; b < bits.size(); b++) begin
         rxd = bits[b];
         if (abort_bit >= 0 && b == abort_bit + 1) begin
            tick(OSR / 2);
            nrst = 1'b0;
            tick(1);
            nrst = 1'b1;
            rxd  = 1'b1;
            return;
         end
         tick(OSR);
      end
      rxd = 1'b1;
   endtask

   // Expected result of a good-stop frame
   task automatic expect_word(input logic [N-1:0] w, input logic bad_par);
      exp_q.push_back(w);
      exp_perr_q.push_back((P == 1) ? bad_par : 1'b0);
   endtask

   // Scoreboard: compare received words against the expected queue
   task automatic drain(input string tag);
      logic [N-1:0] e, g;
      logic         ep, gp;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e  = exp_q.pop_front();
         g  = got_q.pop_front();
         ep = exp_perr_q.pop_front();
         gp = got_perr_q.pop_front();
         check({tag, "_data"}, 32'(g), 32'(e));
         check({tag, "_perr"}, 32'(gp), 32'(ep));
      end
      exp_q.delete();
      exp_perr_q.delete();
      got_q.delete();
      got_perr_q.delete();
      got_cyc_q.delete();
   endtask

   initial begin
      int unsigned t0, v0, f0, p0, busy_cyc, lat;
      logic [N-1:0] w;
      logic         bad;

      // Reset
      nrst = 1'b0;
      rxd  = 1'b1;
      tick(3);
      check("rst_data", 32'(data), 32'(0));
      check("rst_valid", 32'(valid), 32'(0));
      check("rst_ferr", 32'(frame_err), 32'(0));
      check("rst_perr", 32'(parity_err), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      nrst = 1'b1;
      tick(5);

      // Single frame 0xA5 with latency check
      f0 = ferr_n;
      p0 = perr_n;
      t0 = cyc;
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      tick(4);
      lat = (got_cyc_q.size() > 0) ? got_cyc_q[0] - t0 : 0;
      check("a5_latency", lat, 32'(3 + OSR / 2 + OSR * (N + 1 + P)));
      check("a5_ferr", ferr_n - f0, 32'(0));
      check("a5_perr_n", perr_n - p0, 32'(0));
      check("a5_busy", 32'(busy), 32'(0));
      expect_word(8'hA5, 1'b0);
      drain("a5");

      // Random frames with random idle gaps
      for (int i = 0; i < 8; i++) begin
         w   = N'($urandom);
         bad = (P == 1) && ($urandom_range(0, 3) == 0);
         send_frame(w, bad, 1'b1, -1);
         expect_word(w, bad);
         tick($urandom_range(0, OSR));
      end
      tick(4);
      drain("rand");

      // Back-to-back 0x00 then 0xFF, no idle gap
      send_frame(8'h00, 1'b0, 1'b1, -1);
      send_frame(8'hFF, 1'b0, 1'b1, -1);
      tick(4);
      expect_word(8'h00, 1'b0);
      expect_word(8'hFF, 1'b0);
      drain("b2b");

      // False start: line low for 5 cycles only
      v0 = valid_n;
      f0 = ferr_n;
      busy_cyc = 0;
      rxd = 1'b0;
      tick(5);
      rxd = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (busy) busy_cyc++;
      end
      check("fs_busy_seen", 32'(busy_cyc >= 1), 32'(1));
      check("fs_busy_max", 32'(busy_cyc <= OSR / 2 + 1), 32'(1));
      check("fs_valid", valid_n - v0, 32'(0));
      check("fs_ferr", ferr_n - f0, 32'(0));
      check("fs_state", 32'(dbg_state), 32'(IDLE));

      // Framing error: 0x3C with low stop bit, then line held low (break)
      v0 = valid_n;
      f0 = ferr_n;
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      rxd = 1'b0;
      tick(40);
      check("fe_ferr", ferr_n - f0, 32'(1));
      check("fe_valid", valid_n - v0, 32'(0));
      check("fe_data_hold", 32'(data), 32'(8'hFF));
      check("fe_busy_low_line", 32'(busy), 32'(1));
      rxd = 1'b1;
      tick(4);
      check("fe_busy_release", 32'(busy), 32'(0));
      check("fe_state", 32'(dbg_state), 32'(IDLE));

`ifdef UART_RX_PARITY_EN
      // Parity: 0x81 has even weight, so parity bit 1 is wrong, 0 is right
      p0 = perr_n;
      send_frame(8'h81, 1'b1, 1'b1, -1);
      tick(4);
      expect_word(8'h81, 1'b1);
      check("par_bad_perr_n", perr_n - p0, 32'(1));
      drain("par_bad");
      p0 = perr_n;
      send_frame(8'h81, 1'b0, 1'b1, -1);
      tick(4);
      expect_word(8'h81, 1'b0);
      check("par_ok_perr_n", perr_n - p0, 32'(0));
      drain("par_ok");
`endif

      // Reset pulse during data bit 4 aborts the frame
      v0 = valid_n;
      f0 = ferr_n;
      p0 = perr_n;
      send_frame(8'h5A, 1'b0, 1'b1, 4);
      check("mr_data_rst", 32'(data), 32'(0));
      check("mr_busy_rst", 32'(busy), 32'(0));
      tick(OSR * 12);
      check("mr_valid", valid_n - v0, 32'(0));
      check("mr_ferr", ferr_n - f0, 32'(0));
      check("mr_perr", perr_n - p0, 32'(0));
      check("mr_data_after", 32'(data), 32'(0));
      check("mr_state", 32'(dbg_state), 32'(IDLE));
      send_frame(8'h5A, 1'b0, 1'b1, -1);
      tick(4);
      expect_word(8'h5A, 1'b0);
      drain("mr_next");

      $display("%0d/%0d checks passed", pass_cnt, n_chk);
      $finish;
   end

endmodule
